// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR), one stage per amount bit, latency SHW cycles.
// Backpressure: every stage holds while out_valid & !out_ready; in_ready mirrors that advance.
module barrel_shift_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err
);

    localparam logic [2:0] MODE_SLL = 3'd0;
    localparam logic [2:0] MODE_SRL = 3'd1;
    localparam logic [2:0] MODE_SRA = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic             carry;
    } stage_t;

    // Carry of a composed shift equals the carry of its last non-zero partial shift,
    // so each stage overwrites the carry only when it actually moves the data.
    function automatic stage_t shift_stage(input logic [WIDTH-1:0] d,
                                           input logic             c,
                                           input logic [2:0]       mode,
                                           input logic             en,
                                           input int               sh);
        stage_t         r;
        logic [WIDTH:0] ext;
        r.dat   = d;
        r.carry = c;
        ext     = '0;
        if (en) begin
            case (mode)
                MODE_SLL: begin
                    ext     = {1'b0, d} << sh;
                    r.dat   = ext[WIDTH-1:0];
                    r.carry = ext[WIDTH];
                end
                MODE_SRL: begin
                    ext     = {d, 1'b0} >> sh;
                    r.dat   = ext[WIDTH:1];
                    r.carry = ext[0];
                end
                MODE_SRA: begin
                    ext     = $signed({d, 1'b0}) >>> sh;
                    r.dat   = ext[WIDTH:1];
                    r.carry = ext[0];
                end
                MODE_ROL: begin
                    r.dat   = (d << sh) | (d >> (WIDTH - sh));
                    r.carry = r.dat[0];
                end
                MODE_ROR: begin
                    r.dat   = (d >> sh) | (d << (WIDTH - sh));
                    r.carry = r.dat[WIDTH-1];
                end
                default: begin
                    r.dat   = d;
                    r.carry = c;
                end
            endcase
        end
        return r;
    endfunction

    logic [WIDTH-1:0] data_q [SHW];
    logic [WIDTH-1:0] data_d [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    logic [SHW-1:0]   amt_d  [SHW];
    logic [2:0]       mode_q [SHW];
    logic [2:0]       mode_d [SHW];
    logic [SHW-1:0]   vld_q, vld_d;
    logic [SHW-1:0]   carry_q, carry_d;
    logic [SHW-1:0]   err_q, err_d;
    logic             advance;
    stage_t           st;

    always_comb begin
        advance = !vld_q[SHW-1] || out_ready;
        vld_d   = '0;
        carry_d = '0;
        err_d   = '0;

        // Stage 0 consumes the amount MSB straight from the input port.
        st         = shift_stage(in_data, 1'b0, in_mode, in_amt[SHW-1], WIDTH / 2);
        data_d[0]  = st.dat;
        carry_d[0] = st.carry;
        amt_d[0]   = in_amt;
        mode_d[0]  = in_mode;
        vld_d[0]   = in_valid;
        err_d[0]   = (in_mode > MODE_ROR);

        for (int k = 1; k < SHW; k++) begin
            st         = shift_stage(data_q[k-1], carry_q[k-1], mode_q[k-1],
                                     amt_q[k-1][SHW-1-k], WIDTH >> (k + 1));
            data_d[k]  = st.dat;
            carry_d[k] = st.carry;
            amt_d[k]   = amt_q[k-1];
            mode_d[k]  = mode_q[k-1];
            vld_d[k]   = vld_q[k-1];
            err_d[k]   = err_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            carry_q <= '0;
            err_q   <= '0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q   <= vld_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = vld_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_carry = carry_q[SHW-1];
    assign out_err   = err_q[SHW-1];
    assign out_zero  = ~|data_q[SHW-1];

endmodule

// File: doc/barrel_shift_pipe.md
BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; SHALL be derived only, never overridden.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 in_valid  input  1  input word and controls present.
REQ-006 in_ready  output  1  block accepts the input this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_amt  input  SHW  shift amount, 0..WIDTH-1.
REQ-009 in_mode  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 illegal.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  WIDTH  shifted result.
REQ-013 out_carry  output  1  last bit shifted or rotated out.
REQ-014 out_zero  output  1  out_data is all zero.
REQ-015 out_err  output  1  the word was issued with an illegal mode.

Function
REQ-016 The datapath SHALL be SHW cascaded stages; stage k shifts by 2^(SHW-1-k) when that amount bit is set, followed by a pipeline register.
REQ-017 Mode, amount remainder, valid and carry state SHALL be registered alongside data in every stage, so each word uses its own controls.
REQ-018 Latency SHALL be exactly SHW cycles from acceptance to out_valid with no stall (5 at WIDTH=32).
REQ-019 advance = !out_valid | out_ready; all stages SHALL shift together only when advance=1, otherwise hold.
REQ-020 in_ready SHALL equal advance; a word is accepted when in_valid & in_ready.
REQ-021 A cycle with advance=1 and no accepted word SHALL insert a bubble (valid=0); bubbles are not collapsed.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_carry, out_zero and out_err SHALL hold stable.
REQ-023 SLL/SRL SHALL zero-fill; SRA SHALL fill with in_data[WIDTH-1]; ROL/ROR SHALL wrap modulo WIDTH.
REQ-024 in_amt=0 SHALL give out_data=in_data and out_carry=0 for every mode.
REQ-025 For amount n>0: SLL carry=in_data[WIDTH-n]; SRL and SRA carry=in_data[n-1]; ROL carry=out_data[0]; ROR carry=out_data[WIDTH-1].
REQ-026 out_zero SHALL be computed from the final-stage data, so it stays coherent with out_data.
REQ-027 An illegal mode SHALL give out_data=in_data, out_carry=0 and out_err=1, and SHALL NOT stall the pipeline.
REQ-028 out_err SHALL be 0 for all legal modes.
REQ-029 out_valid SHALL be 1 only for accepted words; each accepted word SHALL appear exactly once, in order.

Reset
REQ-030 rst_n=0 SHALL immediately clear all stage valid bits, data, carry and error registers, without waiting for clk.
REQ-031 During reset, out_valid=0, out_data=0, out_carry=0, out_err=0 and out_zero=1.
REQ-032 in_ready SHALL be 1 during reset; words presented while rst_n=0 SHALL be discarded.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight words; none SHALL emerge after release.
REQ-034 The first accepted word after release SHALL emerge after exactly SHW cycles.

Verification (WIDTH=32)
REQ-035 SLL, in_data=0x8000_0001, amt=1, out_ready=1 -> 5 cycles later out_data=0x0000_0002, out_carry=1, out_zero=0.
REQ-036 SRA, in_data=0x8000_0000, amt=31 -> out_data=0xFFFF_FFFF, out_carry=0; then SRL, 0x0000_0001, amt=1 -> out_data=0, out_carry=1, out_zero=1.
REQ-037 ROR, 0x0000_00F1, amt=4 -> out_data=0x1000_000F, out_carry=0; ROL, 0x8000_0000, amt=1 -> out_data=0x1, out_carry=1.
REQ-038 Back-to-back words with out_ready=0 for cycles 6-8 -> in_ready=0 and out_data stable during the stall; all words arrive in order, none lost or duplicated.
REQ-039 in_mode=110, in_data=0x1234_5678 -> out_data=0x1234_5678, out_err=1; the following SLL word -> out_err=0.
REQ-040 rst_n pulsed low with 3 words in flight -> outputs clear immediately; no word emerges; a new word emerges exactly 5 cycles after acceptance.
